// File: rtl/systolic_result_drain.sv
// Result drain for an N x N systolic array: times the compute window after start,
// snapshots every PE accumulator, clears the array and streams results row-major.
module systolic_result_drain #(
  parameter int unsigned N              = 3,
  parameter int unsigned DW             = 17,
  parameter int unsigned COMPUTE_CYCLES = 3 * N - 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [N*N*DW-1:0]     c_flat,
  output logic                  acc_clr,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         out_data,
  output logic [$clog2(N)-1:0]  out_row,
  output logic [$clog2(N)-1:0]  out_col,
  output logic                  out_last,
  output logic                  done
);

  localparam int unsigned NE       = N * N;
  localparam int unsigned IW       = $clog2(NE);
  localparam int unsigned RW       = $clog2(N);
  localparam int unsigned CW       = $clog2(COMPUTE_CYCLES + 1);
  localparam int unsigned LAST_IDX = NE - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_SEND = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [DW-1:0]   res_q [NE];
  logic [DW-1:0]   res_d [NE];
  logic            acc_clr_q, acc_clr_d;
  logic            done_q, done_d;

  logic            capture_c;
  logic            xfer_c;
  logic            last_c;

  assign capture_c = (state_q == S_WAIT) && (cnt_q == '0);
  assign xfer_c    = (state_q == S_SEND) && out_ready;
  assign last_c    = (idx_q == IW'(LAST_IDX));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured from IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start)            state_d = S_WAIT;
      S_WAIT: if (capture_c)        state_d = S_SEND;
      S_SEND: if (xfer_c && last_c) state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  // Datapath next values and stream outputs
  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    res_d     = res_q;
    acc_clr_d = 1'b0;
    done_d    = 1'b0;
    busy      = (state_q != S_IDLE);
    out_valid = (state_q == S_SEND);
    out_data  = '0;
    out_row   = '0;
    out_col   = '0;
    out_last  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) cnt_d = CW'(COMPUTE_CYCLES - 1);
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          for (int unsigned i = 0; i < NE; i++) begin
            res_d[i] = c_flat[i*DW +: DW];
          end
          idx_d     = '0;
          acc_clr_d = 1'b1;
        end
      end
      S_SEND: begin
        out_data = res_q[idx_q];
        out_row  = RW'(idx_q / IW'(N));
        out_col  = RW'(idx_q % IW'(N));
        out_last = last_c;
        if (xfer_c) begin
          if (last_c) begin
            idx_d  = '0;
            done_d = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; the snapshot only changes on the capture edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      res_q     <= '{default: '0};
      acc_clr_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      res_q     <= res_d;
      acc_clr_q <= acc_clr_d;
      done_q    <= done_d;
    end
  end

  assign acc_clr = acc_clr_q;
  assign done    = done_q;

endmodule
